credit_issue_scheduler: RTL and testbench
=========================================

# credit_issue_scheduler

Credit-based, age-aware issue scheduler sharing one downstream issue port among NUM_REQUEST requesters. Sits where a plain priority arbiter would, adding three decisions: critical traffic first, then starved (aged) requesters, then round-robin among requesters holding issue credits, with credits refilled on a fixed period. Holds one issued request in an output register until the consumer acknowledges it.

## Interface
- NUM_REQUEST, 3, number of requesters
- SINGLE_REQUEST_WIDTH_IN_BITS, 64, payload width per requester
- CREDIT_WIDTH, 4, per-requester credit counter width
- CREDIT_INIT, 4, credits loaded at reset and on every refill (≤ 2^CREDIT_WIDTH−1)
- REFILL_PERIOD, 16, cycles between credit refills (≥ 2)
- AGE_LIMIT, 8, waiting cycles before a valid requester is promoted to the aged tier (≥ 1)

- clk_in  input  1  clock, all state on rising edge
- reset_n_in  input  1  asynchronous active-low reset
- request_flatted_in  input  NUM_REQUEST×W  payloads, requester i at bits [i×W +: W]
- request_valid_flatted_in  input  NUM_REQUEST  per-requester valid
- request_critical_flatted_in  input  NUM_REQUEST  per-requester critical flag
- issue_ack_out  output  NUM_REQUEST  one-cycle accept pulse to the winning requester
- request_out  output  W  issued payload
- request_critical_out  output  1  critical flag of issued payload
- request_source_out  output  clog2(NUM_REQUEST)  index of issued requester
- request_valid_out  output  1  output register holds a request
- issue_ack_in  input  1  consumer accepts request_out this cycle

## Operation
- Tiers, highest first: T0 valid & critical; T1 valid & age==AGE_LIMIT; T2 valid & credit>0. Winner = round-robin pick in highest non-empty tier, search starting at last_grant+1 wrapping; no winner if all tiers empty (valid requesters with zero credit and age<AGE_LIMIT wait).
- States: IDLE (output empty), HOLD (output full). Load condition: IDLE, or HOLD with issue_ack_in=1. On load with a winner: payload/critical/source registered, request_valid_out=1, issue_ack_out[winner]=1, last_grant=winner, state HOLD. HOLD with issue_ack_in=1 and no winner: request_valid_out=0, state IDLE. HOLD with issue_ack_in=0: all outputs held stable, no loads.
- Credits: grant from T2 decrements winner's credit; T0 and T1 grants do not consume; credit never below 0.
- Refill counter counts 0..REFILL_PERIOD−1; at REFILL_PERIOD−1 all credits set to CREDIT_INIT, overriding a same-cycle decrement.
- Age: per requester, +1 each cycle valid and not granted, saturating at AGE_LIMIT; cleared on grant or when valid low.
- Reset (any time, including mid-HOLD): state IDLE, all outputs 0, credits CREDIT_INIT, ages 0, refill counter 0, last_grant NUM_REQUEST−1 (first search starts at 0). Held request is dropped.

## Timing
- issue_ack_out is combinational, asserted in the load cycle; requester must present its next request from the following edge. At most one bit set; never set when no load occurs.
- request_out/request_valid_out/request_critical_out/request_source_out registered: visible one cycle after the load cycle.
- Back-to-back: with issue_ack_in held high, one issue per cycle.
- issue_ack_in ignored when request_valid_out=0.
- Requester valid dropping while waiting: no grant, age cleared that edge.

## Structure
- parameters.h: state encodings (IDLE, HOLD), tier indices, clog2 helper macro.
- Sub-module round_robin_picker (NUM_REQUEST-wide request vector + start index -> one-hot grant + found flag), instantiated once per tier; top-level selects highest tier with found=1.

## Test plan
- Reset: pull reset_n_in low during HOLD with request_valid_out=1 -> all outputs 0 asynchronously, after release first grant goes to requester 0.
- Fair RR: all three valid, non-critical, issue_ack_in=1, CREDIT_INIT=4 -> source order 0,1,2,0,1,2…, one issue per cycle, 12 issues before credits exhaust absent refill.
- Critical: requester 1 critical continuously, 0 and 2 valid -> every issue from 1; 0 aged to AGE_LIMIT still loses; credits of 1 stay 4.
- Credit exhaustion: only requester 0 valid, CREDIT_INIT=4, REFILL_PERIOD=16 -> 4 issues in cycles 1–4, stall until aged at AGE_LIMIT=8 (issue, credit stays 0) or refill at cycle 15 restores 4.
- Aging: requesters 0,1 with credit and continuously valid, requester 2 credit 0 -> requester 2 issued once its age reaches 8, ahead of T2.
- Backpressure: issue_ack_in=0 for 10 cycles with payload 0xFFFF_FFFF_FFFF_FFFE loaded -> request_out stable, no issue_ack_out pulse; ack then -> next winner loaded same cycle.

Source files
------------

// File: rtl/credit_issue_scheduler_pkg.sv
// credit_issue_scheduler_pkg: state encoding, tier indices and width helper for the scheduler.
package credit_issue_scheduler_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int TIER_CRIT = 0;
  localparam int TIER_AGED = 1;
  localparam int TIER_CREDIT = 2;
  localparam int NUM_TIERS = 3;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/credit_issue_scheduler_picker.sv
// credit_issue_scheduler_picker: round-robin pick of the first set request at or after start, wrapping.
module credit_issue_scheduler_picker #(
  parameter int N = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic          found
);
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        if (!found && req[i] && i == (int'(start) + k) % N) begin
          grant[i] = 1'b1;
          found = 1'b1;
        end
  end
endmodule

// File: rtl/credit_issue_scheduler.sv
// credit_issue_scheduler: critical > aged > credited round-robin issue into a single held output slot.
module credit_issue_scheduler
  import credit_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQUEST = 3,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int CREDIT_WIDTH = 4,
  parameter int CREDIT_INIT = 4,
  parameter int REFILL_PERIOD = 16,
  parameter int AGE_LIMIT = 8,
  localparam int W = SINGLE_REQUEST_WIDTH_IN_BITS,
  localparam int SW = clog2_min1(NUM_REQUEST)
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic [NUM_REQUEST*W-1:0] request_flatted_in,
  input  logic [NUM_REQUEST-1:0]   request_valid_flatted_in,
  input  logic [NUM_REQUEST-1:0]   request_critical_flatted_in,
  output logic [NUM_REQUEST-1:0]   issue_ack_out,
  output logic [W-1:0]             request_out,
  output logic                     request_critical_out,
  output logic [SW-1:0]            request_source_out,
  output logic                     request_valid_out,
  input  logic                     issue_ack_in
);
  localparam int AW = clog2_min1(AGE_LIMIT + 1);
  localparam int RW = clog2_min1(REFILL_PERIOD);
  state_t state, state_d;
  logic [CREDIT_WIDTH-1:0] credit [NUM_REQUEST];
  logic [AW-1:0] age [NUM_REQUEST];
  logic [RW-1:0] refill_cnt;
  logic [SW-1:0] last_grant, start, win;
  logic [NUM_TIERS-1:0][NUM_REQUEST-1:0] tier_req, tier_grant;
  logic [NUM_TIERS-1:0] tier_found;
  logic [NUM_REQUEST-1:0] grant;
  logic load, found, from_credit, refill;
  always_comb begin
    tier_req = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      tier_req[TIER_CRIT][i] = request_valid_flatted_in[i] & request_critical_flatted_in[i];
      tier_req[TIER_AGED][i] = request_valid_flatted_in[i] && age[i] == AW'(AGE_LIMIT);
      tier_req[TIER_CREDIT][i] = request_valid_flatted_in[i] && credit[i] != '0;
    end
  end
  assign start = (last_grant == SW'(NUM_REQUEST - 1)) ? '0 : last_grant + SW'(1);
  for (genvar t = 0; t < NUM_TIERS; t++) begin : g_tier
    credit_issue_scheduler_picker #(.N(NUM_REQUEST), .IW(SW)) u_picker (
      .req(tier_req[t]),
      .start(start),
      .grant(tier_grant[t]),
      .found(tier_found[t])
    );
  end
  always_comb begin
    grant = tier_found[TIER_CRIT] ? tier_grant[TIER_CRIT]
          : tier_found[TIER_AGED] ? tier_grant[TIER_AGED] : tier_grant[TIER_CREDIT];
    found = |tier_found;
    from_credit = !tier_found[TIER_CRIT] && !tier_found[TIER_AGED];
    win = '0;
    for (int i = 0; i < NUM_REQUEST; i++)
      if (grant[i]) win = SW'(i);
  end
  // Gated by reset so the combinational ack is also quiet while reset is held.
  assign load = reset_n_in && (state == IDLE || issue_ack_in);
  assign issue_ack_out = (load && found) ? grant : '0;
  assign refill = refill_cnt == RW'(REFILL_PERIOD - 1);
  assign request_valid_out = state == HOLD;
  always_comb begin
    state_d = state;
    if (load) state_d = found ? HOLD : IDLE;
  end
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      request_out <= '0;
      request_critical_out <= 1'b0;
      request_source_out <= '0;
      last_grant <= SW'(NUM_REQUEST - 1);
      refill_cnt <= '0;
      for (int i = 0; i < NUM_REQUEST; i++) begin
        credit[i] <= CREDIT_WIDTH'(CREDIT_INIT);
        age[i] <= '0;
      end
    end else begin
      if (load && found) begin
        request_out <= request_flatted_in[win*W +: W];
        request_critical_out <= request_critical_flatted_in[win];
        request_source_out <= win;
        last_grant <= win;
      end
      refill_cnt <= refill ? '0 : refill_cnt + RW'(1);
      for (int i = 0; i < NUM_REQUEST; i++) begin
        credit[i] <= refill ? CREDIT_WIDTH'(CREDIT_INIT)
                   : (issue_ack_out[i] && from_credit) ? credit[i] - CREDIT_WIDTH'(1) : credit[i];
        age[i] <= (!request_valid_flatted_in[i] || issue_ack_out[i]) ? '0
                : (age[i] == AW'(AGE_LIMIT)) ? age[i] : age[i] + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_credit_issue_scheduler.sv
// tb_credit_issue_scheduler: directed and random cycles against a tier/credit/age reference model.
module tb_credit_issue_scheduler;
  localparam int N = 3;
  localparam int W = 64;
  localparam int CI = 4;
  localparam int RP = 16;
  localparam int AL = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N*W-1:0] req_flat = '0;
  logic [N-1:0] valid = '0, crit = '0, ack_out;
  logic [W-1:0] req_out;
  logic crit_out, valid_out, ack_in = 1'b0;
  logic [1:0] src_out;
  logic [W-1:0] pay [N];
  int checks = 0, errors = 0;
  int credit_m [N], age_m [N];
  int refill_m, lg_m, src_m;
  bit hold_m, crit_m;
  logic [W-1:0] pay_m;

  credit_issue_scheduler #(
    .NUM_REQUEST(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W), .CREDIT_WIDTH(4),
    .CREDIT_INIT(CI), .REFILL_PERIOD(RP), .AGE_LIMIT(AL)
  ) dut (
    .clk_in(clk),
    .reset_n_in(reset_n),
    .request_flatted_in(req_flat),
    .request_valid_flatted_in(valid),
    .request_critical_flatted_in(crit),
    .issue_ack_out(ack_out),
    .request_out(req_out),
    .request_critical_out(crit_out),
    .request_source_out(src_out),
    .request_valid_out(valid_out),
    .issue_ack_in(ack_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hold_m = 0; crit_m = 0; src_m = 0; pay_m = '0;
    refill_m = 0; lg_m = N - 1;
    for (int i = 0; i < N; i++) begin credit_m[i] = CI; age_m[i] = 0; end
  endtask

  task automatic randomize_pay();
    for (int i = 0; i < N; i++) pay[i] = {$urandom, $urandom};
  endtask

  // One clock: drive inputs, check the combinational ack, step the model, check registered outputs.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] c, input logic a);
    int w, tier, i;
    bit ld, in_tier;
    logic [N-1:0] e;
    valid = v; crit = c; ack_in = a;
    for (int j = 0; j < N; j++) req_flat[j*W +: W] = pay[j];
    #1;
    w = -1; tier = 3;
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < N; k++) begin
        i = (lg_m + 1 + k) % N;
        in_tier = (t == 0) ? c[i] : (t == 1) ? (age_m[i] == AL) : (credit_m[i] > 0);
        if (w < 0 && v[i] && in_tier) begin w = i; tier = t; end
      end
    ld = !hold_m || a;
    e = '0;
    if (ld && w >= 0) e[w] = 1'b1;
    check("issue_ack", ack_out, e);
    @(posedge clk);
    if (ld) begin
      hold_m = w >= 0;
      if (w >= 0) begin pay_m = pay[w]; crit_m = c[w]; src_m = w; lg_m = w; end
    end
    for (int j = 0; j < N; j++) begin
      if (refill_m == RP - 1) credit_m[j] = CI;
      else if (e[j] && tier == 2) credit_m[j]--;
      age_m[j] = (!v[j] || e[j]) ? 0 : (age_m[j] < AL ? age_m[j] + 1 : AL);
    end
    refill_m = (refill_m + 1) % RP;
    #1;
    check("valid_out", valid_out, hold_m);
    if (hold_m) begin
      check("request_out", req_out, pay_m);
      check("source_out", src_out, src_m);
      check("critical_out", crit_out, crit_m);
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    randomize_pay();
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_payload", req_out, 0);
    check("rst_source", src_out, 0);
    check("rst_ack", ack_out, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // Fair round robin across all three, credits drain then refill.
    for (int n = 0; n < 14; n++) begin randomize_pay(); cycle(3'b111, 3'b000, 1'b1); end
    // Requester 1 critical dominates even aged competitors.
    for (int n = 0; n < 20; n++) begin randomize_pay(); cycle(3'b111, 3'b010, 1'b1); end
    // Lone requester exhausts credits and waits for age or refill.
    for (int n = 0; n < 24; n++) begin randomize_pay(); cycle(3'b001, 3'b000, 1'b1); end
    // Backpressure with a known payload held for ten cycles.
    randomize_pay();
    pay[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    cycle(3'b001, 3'b001, 1'b1);
    check("bp_loaded", req_out, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int n = 0; n < 10; n++) begin randomize_pay(); cycle(3'b111, 3'b000, 1'b0); end
    check("bp_stable", req_out, 64'hFFFF_FFFF_FFFF_FFFE);
    randomize_pay();
    cycle(3'b111, 3'b000, 1'b1);
    for (int n = 0; n < 400; n++) begin
      randomize_pay();
      cycle(N'($urandom), ($urandom_range(0, 7) == 0) ? N'($urandom) : '0, $urandom_range(0, 3) != 0);
    end
    // Asynchronous reset while holding a request.
    randomize_pay();
    cycle(3'b111, 3'b000, 1'b0);
    check("pre_reset_hold", valid_out, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", valid_out, 0);
    check("async_payload", req_out, 0);
    check("async_source", src_out, 0);
    check("async_critical", crit_out, 0);
    check("async_ack", ack_out, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    randomize_pay();
    cycle(3'b111, 3'b000, 1'b1);
    check("first_after_reset", src_out, 0);
    for (int n = 0; n < 6; n++) begin randomize_pay(); cycle(3'b111, 3'b000, 1'b1); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
